// File: rtl/mips_pkg.sv
// Shared register-file constants and the writeback request record
// carried through the long-latency result FIFO.
package mips_pkg;
    localparam int REG_COUNT = 32;
    localparam int WIDTH     = 32;
    localparam int IDX_WIDTH = 5;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] dest;
        logic [WIDTH-1:0]     data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate flag.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  wb_req_t                wdata_i,
    input  logic                   pop_i,
    output wb_req_t                head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, rptr_q;
    wb_req_t     mem_q [DEPTH];
    logic        push_ok, pop_ok;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign count_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
endmodule

// File: rtl/writeback_arbiter.sv
// Owns the register-file write port: ALU results win by default, queued
// long-unit results win when empty-handed ALU or after STARVE_LIMIT losses.
module writeback_arbiter
    import mips_pkg::*;
#(
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [IDX_WIDTH-1:0]    alu_dest,
    input  logic [WIDTH-1:0]        alu_data,
    input  logic                    lu_valid,
    output logic                    lu_ready,
    input  logic [IDX_WIDTH-1:0]    lu_dest,
    input  logic [WIDTH-1:0]        lu_data,
    input  logic                    issue_mark,
    input  logic [IDX_WIDTH-1:0]    issue_dest,
    output logic [REG_COUNT-1:0]    busy,
    output logic                    wr_en,
    output logic [IDX_WIDTH-1:0]    dest,
    output logic [WIDTH-1:0]        wr_data,
    output logic [$clog2(QDEPTH):0] q_count
);
    localparam int AGEW = $clog2(STARVE_LIMIT + 1);

    logic [AGEW-1:0]      age_q, age_d;
    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic                 wr_en_q, wr_en_d;
    logic [IDX_WIDTH-1:0] dest_q, dest_d;
    logic [WIDTH-1:0]     data_q, data_d;

    logic    starve, alu_win, pop, push, empty, full;
    wb_req_t head, lu_req;

    assign starve  = (age_q >= AGEW'(STARVE_LIMIT));
    assign alu_win = alu_valid && !starve && (alu_dest != '0);
    assign pop     = !empty && !alu_win;
    // Writes to r0 are accepted but dropped before they reach the queue.
    assign push    = lu_valid && lu_ready && (lu_dest != '0);
    assign lu_req  = '{dest: lu_dest, data: lu_data};

    assign alu_ready = !starve;
    assign lu_ready  = !full;

    wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .wdata_i(lu_req),
        .pop_i  (pop),
        .head_o (head),
        .empty_o(empty),
        .full_o (full),
        .count_o(q_count)
    );

    always_comb begin
        age_d = age_q;
        if (empty || pop)
            age_d = '0;
        else if (!starve)
            age_d = age_q + 1'b1;
    end

    // Set after clear so a reissue to the popping register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (pop)
            busy_d[head.dest] = 1'b0;
        if (issue_mark && issue_dest != '0)
            busy_d[issue_dest] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        wr_en_d = alu_win || pop;
        dest_d  = dest_q;
        data_d  = data_q;
        if (alu_win) begin
            dest_d = alu_dest;
            data_d = alu_data;
        end else if (pop) begin
            dest_d = head.dest;
            data_d = head.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q   <= '0;
            busy_q  <= '0;
            wr_en_q <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            age_q   <= age_d;
            busy_q  <= busy_d;
            wr_en_q <= wr_en_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign dest    = dest_q;
    assign wr_data = data_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-based reference model
// checked every cycle plus literal expectations for each scenario.
module tb_writeback_arbiter;
    import mips_pkg::*;

    localparam int QDEPTH = 4;
    localparam int LIMIT  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 alu_valid = 1'b0, lu_valid = 1'b0, issue_mark = 1'b0;
    logic [IDX_WIDTH-1:0] alu_dest = '0, lu_dest = '0, issue_dest = '0;
    logic [WIDTH-1:0]     alu_data = '0, lu_data = '0;
    logic                 alu_ready, lu_ready, wr_en;
    logic [REG_COUNT-1:0] busy;
    logic [IDX_WIDTH-1:0] dest;
    logic [WIDTH-1:0]     wr_data;
    logic [2:0]           q_count;

    int checks = 0;
    int errors = 0;

    writeback_arbiter #(.QDEPTH(QDEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dest(lu_dest), .lu_data(lu_data),
        .issue_mark(issue_mark), .issue_dest(issue_dest),
        .busy(busy), .wr_en(wr_en), .dest(dest), .wr_data(wr_data), .q_count(q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending results as a queue, loss count as an integer.
    wb_req_t              mq[$];
    int                   mage = 0;
    logic [REG_COUNT-1:0] mbusy = '0;
    logic                 exp_wr = 1'b0;
    logic [IDX_WIDTH-1:0] exp_dest = '0;
    logic [WIDTH-1:0]     exp_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mage   = 0;
            mbusy  = '0;
            exp_wr = 1'b0;
        end else begin
            bit      ready_alu, alu_takes, head_goes, q_takes;
            wb_req_t h;
            ready_alu = (mage < LIMIT);
            alu_takes = alu_valid && ready_alu && alu_dest != 0;
            head_goes = (mq.size() > 0) && !alu_takes;
            q_takes   = lu_valid && (mq.size() < QDEPTH) && lu_dest != 0;
            if (head_goes) h = mq[0];
            if (alu_takes && mbusy[alu_dest]) begin
                errors++;
                $display("FAIL upstream_alu_busy: dest %0d busy", alu_dest);
            end
            if (issue_mark && issue_dest != 0 && mbusy[issue_dest]
                && !(head_goes && h.dest == issue_dest)) begin
                errors++;
                $display("FAIL upstream_issue_busy: dest %0d busy", issue_dest);
            end
            exp_wr = alu_takes || head_goes;
            if (alu_takes) begin
                exp_dest = alu_dest; exp_data = alu_data;
            end else if (head_goes) begin
                exp_dest = h.dest; exp_data = h.data;
            end
            if (head_goes) mbusy[h.dest] = 1'b0;
            if (issue_mark && issue_dest != 0) mbusy[issue_dest] = 1'b1;
            if (mq.size() == 0 || head_goes) mage = 0;
            else if (mage < LIMIT) mage++;
            if (head_goes) void'(mq.pop_front());
            if (q_takes) mq.push_back('{dest: lu_dest, data: lu_data});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_wr_en", 64'(wr_en), 64'(exp_wr));
            chk("m_busy", 64'(busy), 64'(mbusy));
            chk("m_q_count", 64'(q_count), 64'(mq.size()));
            chk("m_lu_ready", 64'(lu_ready), 64'(mq.size() < QDEPTH));
            chk("m_alu_ready", 64'(alu_ready), 64'(mage < LIMIT));
            if (exp_wr) begin
                chk("m_dest", 64'(dest), 64'(exp_dest));
                chk("m_wr_data", 64'(wr_data), 64'(exp_data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  k;
        bit  rdy;
        #2;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_dest", 64'(dest), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_q_count", 64'(q_count), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_lu_ready", 64'(lu_ready), 64'd1);
        step(); step();
        rst = 1'b0;

        // ALU path
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_wr_en", 64'(wr_en), 64'd1);
        chk("alu_dest", 64'(dest), 64'd3);
        chk("alu_data", 64'(wr_data), 64'hDEADBEEF);
        alu_dest = 5'd0;
        step();
        chk("alu_r0_wr_en", 64'(wr_en), 64'd0);
        alu_valid = 1'b0;

        // Long unit with scoreboard
        issue_mark = 1'b1; issue_dest = 5'd7;
        step();
        issue_mark = 1'b0;
        chk("lu_busy_set", 64'(busy[7]), 64'd1);
        lu_valid = 1'b1; lu_dest = 5'd7; lu_data = 32'h55;
        step();
        lu_valid = 1'b0;
        chk("lu_n1_wr_en", 64'(wr_en), 64'd0);
        chk("lu_n1_count", 64'(q_count), 64'd1);
        step();
        chk("lu_wr_en", 64'(wr_en), 64'd1);
        chk("lu_dest", 64'(dest), 64'd7);
        chk("lu_data", 64'(wr_data), 64'h55);
        chk("lu_busy_clr", 64'(busy[7]), 64'd0);

        // Full FIFO while ALU keeps winning
        alu_valid = 1'b1; alu_dest = 5'd10; alu_data = 32'hA0A0;
        lu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lu_dest = 5'(11 + i); lu_data = 32'h1000 + i;
            step();
        end
        chk("full_count", 64'(q_count), 64'd4);
        chk("full_lu_ready", 64'(lu_ready), 64'd0);
        lu_dest = 5'd15; lu_data = 32'h1004;
        step();
        chk("full_refused_count", 64'(q_count), 64'd4);
        chk("full_starve", 64'(alu_ready), 64'd0);
        step();
        chk("full_forced_dest", 64'(dest), 64'd11);
        chk("full_forced_data", 64'(wr_data), 64'h1000);
        chk("full_after_pop_ready", 64'(lu_ready), 64'd1);
        step();
        lu_valid = 1'b0; alu_valid = 1'b0;
        chk("full_refill_count", 64'(q_count), 64'd4);
        chk("full_alu_dest", 64'(dest), 64'd10);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("drain_data", 64'(wr_data), 64'h1000 + 64'(i));
        end
        chk("drain_empty", 64'(q_count), 64'd0);

        // Starvation
        lu_valid = 1'b1; lu_dest = 5'd20; lu_data = 32'hA5;
        alu_valid = 1'b1; alu_dest = 5'd4;
        k = 0; alu_data = 32'h100;
        for (int i = 0; i < 6; i++) begin
            rdy = alu_ready;
            step();
            if (i == 0) lu_valid = 1'b0;
            if (rdy) begin k++; alu_data = 32'h100 + 32'(k); end
            if (i == 4) chk("starve_alu_ready", 64'(alu_ready), 64'd0);
            if (i == 5) begin
                chk("starve_pop_dest", 64'(dest), 64'd20);
                chk("starve_pop_data", 64'(wr_data), 64'hA5);
                chk("starve_ready_back", 64'(alu_ready), 64'd1);
            end
        end
        step();
        alu_valid = 1'b0;
        chk("starve_held_dest", 64'(dest), 64'd4);
        chk("starve_held_data", 64'(wr_data), 64'h105);

        // Same-cycle set and clear
        issue_mark = 1'b1; issue_dest = 5'd9;
        step();
        issue_mark = 1'b0;
        lu_valid = 1'b1; lu_dest = 5'd9; lu_data = 32'h99;
        step();
        lu_valid = 1'b0;
        issue_mark = 1'b1; issue_dest = 5'd9;
        step();
        issue_mark = 1'b0;
        chk("setclr_dest", 64'(dest), 64'd9);
        chk("setclr_busy", 64'(busy[9]), 64'd1);

        // Reset mid-stream
        issue_mark = 1'b1; issue_dest = 5'd21;
        step();
        issue_mark = 1'b0;
        alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'h55AA;
        lu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lu_dest = 5'(21 + i); lu_data = 32'h2000 + i;
            step();
        end
        lu_valid = 1'b0;
        chk("pre_rst_count", 64'(q_count), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", 64'(q_count), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        alu_valid = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_write", 64'(wr_en), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
